csr_file: RTL and testbench

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_pkg.sv | 23 ++
 rtl/csr_counter.sv | 37 +++
 rtl/csr_file.sv | 129 ++++++++++++
 tb/tb_csr_file.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the CSR file: address map, access opcodes and legal counter widths.
package csr_pkg;

  localparam logic [11:0] ADR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADR_INSTRETH      = 12'hC82;
  localparam logic [11:0] ADR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADR_MCOUNTINHIBIT = 12'h320;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam int CNT_WIDTH_MIN = 33;
  localparam int CNT_WIDTH_MAX = 64;

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with independent lo/hi half writes; a write of either half
// suppresses the increment for that cycle.
module csr_counter
  import csr_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_lo_i,
  input  logic [WIDTH-33:0] wdata_hi_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0] = wdata_lo_i;
      if (wr_hi_i) count_d[WIDTH-1:32] = wdata_hi_i;
    end else if (inc_en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine CSR file: cycle/instret counters, mscratch, optional mcountinhibit.
// Optional feature macro: CSR_INHIBIT_EN adds mcountinhibit at 0x320.
module csr_file
  import csr_pkg::*;
#(
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [31:0] MSCRATCH_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_req,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_adr,
  input  logic [31:0] csr_wdata,
  input  logic        instr_retired,
  output logic [31:0] csr_rdata,
  output logic        csr_valid,
  output logic        csr_illegal
);

  logic [COUNTER_WIDTH-1:0] cycle_cnt, instret_cnt;
  logic [63:0] cycle_ext, instret_ext;
  logic [31:0] mscratch_q;
  logic [31:0] rdata_q;
  logic        valid_q, illegal_q;
  logic        inh_cy, inh_ir;

  logic [31:0] old_val, new_val;
  logic        mapped, read_only, is_write, illegal, do_write;

  assign cycle_ext   = 64'(cycle_cnt);
  assign instret_ext = 64'(instret_cnt);

  always_comb begin
    old_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (csr_adr)
      ADR_CYCLE:     begin old_val = cycle_ext[31:0];    read_only = 1'b1; end
      ADR_CYCLEH:    begin old_val = cycle_ext[63:32];   read_only = 1'b1; end
      ADR_INSTRET:   begin old_val = instret_ext[31:0];  read_only = 1'b1; end
      ADR_INSTRETH:  begin old_val = instret_ext[63:32]; read_only = 1'b1; end
      ADR_MCYCLE:    old_val = cycle_ext[31:0];
      ADR_MCYCLEH:   old_val = cycle_ext[63:32];
      ADR_MINSTRET:  old_val = instret_ext[31:0];
      ADR_MINSTRETH: old_val = instret_ext[63:32];
      ADR_MSCRATCH:  old_val = mscratch_q;
`ifdef CSR_INHIBIT_EN
      ADR_MCOUNTINHIBIT: old_val = {29'b0, inh_ir, 1'b0, inh_cy};
`endif
      default:       mapped = 1'b0;
    endcase
  end

  // RS/RC with an empty mask is a pure read, so it is legal even on read-only CSRs.
  always_comb begin
    is_write = (csr_op == OP_RW) || ((csr_op != OP_READ) && (csr_wdata != 32'b0));
    case (csr_op)
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = old_val | csr_wdata;
      OP_RC:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  assign illegal  = !mapped || (read_only && is_write);
  assign do_write = csr_req && !illegal && is_write;

`ifdef CSR_INHIBIT_EN
  logic inh_cy_q, inh_ir_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      inh_cy_q <= 1'b0;
      inh_ir_q <= 1'b0;
    end else if (do_write && csr_adr == ADR_MCOUNTINHIBIT) begin
      inh_cy_q <= new_val[0];
      inh_ir_q <= new_val[2];
    end
  end
  assign inh_cy = inh_cy_q;
  assign inh_ir = inh_ir_q;
`else
  assign inh_cy = 1'b0;
  assign inh_ir = 1'b0;
`endif

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_cycle (
    .clk        (clk),
    .rst        (rst),
    .inc_en_i   (!inh_cy),
    .wr_lo_i    (do_write && csr_adr == ADR_MCYCLE),
    .wr_hi_i    (do_write && csr_adr == ADR_MCYCLEH),
    .wdata_lo_i (new_val),
    .wdata_hi_i (new_val[COUNTER_WIDTH-33:0]),
    .count_o    (cycle_cnt)
  );

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_instret (
    .clk        (clk),
    .rst        (rst),
    .inc_en_i   (instr_retired && !inh_ir),
    .wr_lo_i    (do_write && csr_adr == ADR_MINSTRET),
    .wr_hi_i    (do_write && csr_adr == ADR_MINSTRETH),
    .wdata_lo_i (new_val),
    .wdata_hi_i (new_val[COUNTER_WIDTH-33:0]),
    .count_o    (instret_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mscratch_q <= MSCRATCH_RST;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (do_write && csr_adr == ADR_MSCRATCH) mscratch_q <= new_val;
      valid_q <= csr_req;
      if (csr_req) begin
        rdata_q   <= illegal ? 32'b0 : old_val;
        illegal_q <= illegal;
      end
    end
  end

  assign csr_rdata   = rdata_q;
  assign csr_valid   = valid_q;
  assign csr_illegal = illegal_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; mcountinhibit cases follow CSR_INHIBIT_EN.
module tb_csr_file;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_req = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_adr = 12'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic        instr_retired = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_valid;
  logic        csr_illegal;

  int checks = 0;
  int errors = 0;

  csr_file dut (
    .clk           (clk),
    .rst           (rst),
    .csr_req       (csr_req),
    .csr_op        (csr_op),
    .csr_adr       (csr_adr),
    .csr_wdata     (csr_wdata),
    .instr_retired (instr_retired),
    .csr_rdata     (csr_rdata),
    .csr_valid     (csr_valid),
    .csr_illegal   (csr_illegal)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one,
  // with the response for this request on the outputs.
  task automatic access(input logic [1:0] op, input logic [11:0] adr, input logic [31:0] wd);
    csr_req   = 1'b1;
    csr_op    = op;
    csr_adr   = adr;
    csr_wdata = wd;
    @(posedge clk);
    #1;
    csr_req = 1'b0;
    $display("access op=%0d adr=%h wdata=%h -> rdata=%h valid=%0b illegal=%0b",
             op, adr, wd, csr_rdata, csr_valid, csr_illegal);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_resp(input string name, input logic [31:0] rd, input logic ill);
    checks++;
    if (csr_rdata !== rd || csr_valid !== 1'b1 || csr_illegal !== ill) begin
      errors++;
      $display("FAIL %s: got rdata=%h valid=%0b illegal=%0b, want rdata=%h valid=1 illegal=%0b",
               name, csr_rdata, csr_valid, csr_illegal, rd, ill);
    end
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // A request presented during reset must be dropped.
    rst = 1'b1;
    csr_req = 1'b1; csr_op = OP_RW; csr_adr = ADR_MSCRATCH; csr_wdata = 32'h1234;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    csr_req = 1'b0;
    checks++;
    if (csr_valid !== 1'b0 || csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b rdata=%h illegal=%0b, want 0/0/0",
               csr_valid, csr_rdata, csr_illegal);
    end
    access(OP_READ, ADR_CYCLE, 32'h0);
    expect_resp("reset_cycle_first", 32'd0, 1'b0);
    access(OP_READ, ADR_CYCLE, 32'h0);
    expect_resp("reset_cycle_second", 32'd2 - 32'd1, 1'b0);
    access(OP_READ, ADR_MSCRATCH, 32'h0);
    expect_resp("reset_mscratch_no_write", 32'h0, 1'b0);
  endtask

  task automatic test_cycle();
    do_reset();
    idle(5);
    access(OP_READ, ADR_CYCLE, 32'h0);
    expect_resp("cycle_at_6", 32'd5, 1'b0);
    access(OP_READ, ADR_CYCLEH, 32'h0);
    expect_resp("cycle_hi", 32'd0, 1'b0);
  endtask

  task automatic test_carry();
    do_reset();
    access(OP_RW, ADR_MCYCLEH, 32'h0);
    expect_resp("carry_write_hi", 32'd0, 1'b0);
    access(OP_RW, ADR_MCYCLE, 32'hFFFF_FFFF);
    expect_resp("carry_write_lo_no_inc", 32'd0, 1'b0);
    access(OP_READ, ADR_MCYCLE, 32'h0);
    expect_resp("carry_lo_written", 32'hFFFF_FFFF, 1'b0);
    access(OP_READ, ADR_MCYCLEH, 32'h0);
    expect_resp("carry_hi_one", 32'd1, 1'b0);
    access(OP_READ, ADR_CYCLE, 32'h0);
    expect_resp("carry_lo_wrapped", 32'd1, 1'b0);
  endtask

  task automatic test_illegal();
    do_reset();
    access(OP_RW, ADR_INSTRET, 32'd5);
    expect_resp("ro_write_illegal", 32'h0, 1'b1);
    access(OP_READ, ADR_INSTRET, 32'h0);
    expect_resp("ro_instret_unchanged", 32'h0, 1'b0);
    access(OP_RS, ADR_INSTRET, 32'h0);
    expect_resp("ro_rs_zero_legal", 32'h0, 1'b0);
    access(OP_RC, ADR_CYCLE, 32'h1);
    expect_resp("ro_rc_cycle_illegal", 32'h0, 1'b1);
    access(OP_READ, 12'h123, 32'h0);
    expect_resp("unmapped_illegal", 32'h0, 1'b1);
  endtask

  task automatic test_mscratch();
    access(OP_RW, ADR_MSCRATCH, 32'hA5A5_0000);
    expect_resp("mscratch_rw_old", 32'h0, 1'b0);
    access(OP_RC, ADR_MSCRATCH, 32'hA500_0000);
    expect_resp("mscratch_rc_old", 32'hA5A5_0000, 1'b0);
    access(OP_RS, ADR_MSCRATCH, 32'h0000_000F);
    expect_resp("mscratch_rc_result", 32'h00A5_0000, 1'b0);
    access(OP_RC, ADR_MSCRATCH, 32'h0);
    expect_resp("mscratch_rs_result", 32'h00A5_000F, 1'b0);
    access(OP_READ, ADR_MSCRATCH, 32'h0);
    expect_resp("mscratch_rc_zero_nochange", 32'h00A5_000F, 1'b0);
  endtask

  task automatic test_instret();
    do_reset();
    instr_retired = 1'b1;
    idle(3);
    access(OP_RW, ADR_MINSTRET, 32'd7);
    instr_retired = 1'b0;
    expect_resp("instret_write_old", 32'd3, 1'b0);
    access(OP_READ, ADR_INSTRET, 32'h0);
    expect_resp("instret_write_priority", 32'd7, 1'b0);
    access(OP_RW, ADR_MINSTRETH, 32'hFFFF_FFFF);
    expect_resp("instret_hi_write_old", 32'd0, 1'b0);
    access(OP_READ, ADR_INSTRET, 32'h0);
    expect_resp("instret_lo_kept", 32'd7, 1'b0);
    access(OP_READ, ADR_INSTRETH, 32'h0);
    expect_resp("instret_hi_written", 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    access(OP_RW, ADR_MSCRATCH, 32'd1);
    access(OP_RW, ADR_MSCRATCH, 32'd2);
    expect_resp("b2b_second", 32'd1, 1'b0);
    access(OP_RW, ADR_MSCRATCH, 32'd3);
    expect_resp("b2b_third", 32'd2, 1'b0);
    access(OP_READ, ADR_MSCRATCH, 32'h0);
    expect_resp("b2b_read", 32'd3, 1'b0);
    idle(1);
    checks++;
    if (csr_valid !== 1'b0 || csr_rdata !== 32'd3) begin
      errors++;
      $display("FAIL idle_valid_drop: got valid=%0b rdata=%h, want valid=0 rdata=00000003",
               csr_valid, csr_rdata);
    end
  endtask

  task automatic test_inhibit();
    do_reset();
`ifdef CSR_INHIBIT_EN
    access(OP_RW, ADR_MCOUNTINHIBIT, 32'h1);
    expect_resp("inhibit_write", 32'h0, 1'b0);
    access(OP_READ, ADR_CYCLE, 32'h0);
    expect_resp("inhibit_cycle_frozen_a", 32'd1, 1'b0);
    instr_retired = 1'b1;
    idle(10);
    instr_retired = 1'b0;
    access(OP_READ, ADR_CYCLE, 32'h0);
    expect_resp("inhibit_cycle_frozen_b", 32'd1, 1'b0);
    access(OP_READ, ADR_INSTRET, 32'h0);
    expect_resp("inhibit_instret_counts", 32'd10, 1'b0);
    access(OP_RW, ADR_MCYCLE, 32'd100);
    access(OP_READ, ADR_MCYCLE, 32'h0);
    expect_resp("inhibit_write_applies", 32'd100, 1'b0);
    access(OP_RW, ADR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
    access(OP_READ, ADR_MCOUNTINHIBIT, 32'h0);
    expect_resp("inhibit_impl_bits", 32'h5, 1'b0);
`else
    access(OP_READ, ADR_MCOUNTINHIBIT, 32'h0);
    expect_resp("inhibit_absent_illegal", 32'h0, 1'b1);
    idle(3);
    access(OP_READ, ADR_CYCLE, 32'h0);
    expect_resp("inhibit_absent_counting", 32'd4, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_carry();
    test_illegal();
    test_mscratch();
    test_instret();
    test_back_to_back();
    test_inhibit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
